regfile_wr_arbiter: RTL

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: the WB stage shares one write port with a small
// FIFO of multi-cycle (div/load) results, with a starvation guard and pending-write lookup.
module regfile_wr_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    localparam int RADDR_WIDTH = 5,
    localparam int RDATA_WIDTH = 32,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   wb_we_in,
    input  logic [RADDR_WIDTH-1:0] wb_waddr_in,
    input  logic [RDATA_WIDTH-1:0] wb_wdata_in,
    output logic                   wb_stall_out,
    input  logic                   mc_valid_in,
    output logic                   mc_ready_out,
    input  logic [RADDR_WIDTH-1:0] mc_waddr_in,
    input  logic [RDATA_WIDTH-1:0] mc_wdata_in,
    output logic                   rf_we_out,
    output logic [RADDR_WIDTH-1:0] rf_waddr_out,
    output logic [RDATA_WIDTH-1:0] rf_wdata_out,
    input  logic [RADDR_WIDTH-1:0] rd1_addr_in,
    input  logic [RADDR_WIDTH-1:0] rd2_addr_in,
    output logic                   pend1_out,
    output logic                   pend2_out,
    output logic [CW-1:0]          count_out
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [RADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [RDATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]       r_valid;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [SW-1:0]          r_starve;

    logic                   w_nonempty;
    logic                   w_force;
    logic                   w_grant_head;
    logic                   w_enq;
    logic [DEPTH-1:0]       w_match1;
    logic [DEPTH-1:0]       w_match2;

    // Reset masks the queue immediately so a flushed entry can never win the port.
    assign w_nonempty   = !reset_in && (r_count != '0);
    assign w_force      = (r_starve == SW'(STARVE_LIMIT));
    assign w_grant_head = w_nonempty && (w_force || !wb_we_in);

    assign wb_stall_out = wb_we_in && w_grant_head;
    assign mc_ready_out = reset_in || (r_count < CW'(DEPTH));
    assign count_out    = reset_in ? '0 : r_count;

    // Writes to x0 complete the handshake but never occupy a slot.
    assign w_enq = !reset_in && mc_valid_in && (r_count < CW'(DEPTH)) && (mc_waddr_in != '0);

    always_comb begin
        rf_we_out    = 1'b0;
        rf_waddr_out = '0;
        rf_wdata_out = '0;
        if (w_grant_head) begin
            rf_we_out    = 1'b1;
            rf_waddr_out = r_addr[r_rd_ptr];
            rf_wdata_out = r_data[r_rd_ptr];
        end else if (wb_we_in) begin
            rf_we_out    = 1'b1;
            rf_waddr_out = wb_waddr_in;
            rf_wdata_out = wb_wdata_in;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match1[gi] = r_valid[gi] && (r_addr[gi] == rd1_addr_in);
            assign w_match2[gi] = r_valid[gi] && (r_addr[gi] == rd2_addr_in);
        end
    endgenerate

    assign pend1_out = !reset_in && (rd1_addr_in != '0) && (|w_match1);
    assign pend2_out = !reset_in && (rd2_addr_in != '0) && (|w_match2);

    always_ff @(posedge clk_in) begin
        if (w_enq) begin
            r_addr[r_wr_ptr] <= mc_waddr_in;
            r_data[r_wr_ptr] <= mc_wdata_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_enq && (r_wr_ptr == PW'(i))) begin
                    r_valid[i] <= 1'b1;
                end else if (w_grant_head && (r_rd_ptr == PW'(i))) begin
                    r_valid[i] <= 1'b0;
                end
            end

            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_grant_head) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end

            case ({w_enq, w_grant_head})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (!w_nonempty || w_grant_head) begin
                r_starve <= '0;
            end else if (!w_force) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

endmodule
